data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter that shares the single-ported data memory between the CPU datapath (port 0) and an auxiliary loader/debug master (port 1). Accepts at most one access per cycle via valid/ready, grants round-robin on contention, and drives the memory's address, write-data and read/write strobes from registered outputs. Returns a one-cycle response pulse per accepted access carrying read data or an out-of-range error. Sits between the requesters and the data memory, which reads combinationally and writes on the rising clock edge.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 32, word-address width; the address is a word index, not a byte address
- DEPTH, 65, valid words at 0..DEPTH-1
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  access request
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  word address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_ready / req1_ready  out  1  grant; combinational from both valids and the priority pointer
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data, valid with rsp_valid on reads
- rsp0_err / rsp1_err  out  1  out-of-range address, valid with rsp_valid
- mem_address  out  ADDR_W  to the memory address input
- mem_writeData  out  DATA_W  to the memory write-data input
- mem_memRead / mem_memWrite  out  1  memory strobes, never both high
- mem_readData  in  DATA_W  from the memory; high-Z when mem_memRead is low

## Operation
- Acceptance: requester i is accepted in a cycle where reqi_valid && reqi_ready. The requester holds valid and payload stable until accepted.
- Arbitration: single valid gets ready. Both valid: grant the port not granted last. Pointer updates only on acceptance.
- At most one ready high per cycle. ready is 0 for a port whose valid is 0.
- Command stage (registered): on acceptance, latch id, we, addr and wdata. If addr < DEPTH, the next cycle drives mem_address/mem_writeData and asserts mem_memRead (read) or mem_memWrite (write). If addr >= DEPTH, no strobe is asserted and the err flag is carried forward.
- Response stage (registered): at the end of the command cycle, capture mem_readData for in-range reads. Pulse rsp{id}_valid; rdata = captured word, or 0 for writes and errors; err = range flag.
- Idle command cycle: strobes 0; mem_address and mem_writeData hold their last values.
- Fully pipelined: back-to-back accepts every cycle, no bubbles.
- Read-after-write to the same address in consecutive accepts returns the new data, because the write commits at the edge ending its command cycle.

## Timing
- Accept at cycle T -> memory strobe during T+1 -> rsp_valid high during T+2 for exactly one cycle. Latency 2, throughput 1 per cycle.
- A write commits at the rising edge ending T+1.
- Reset values: all ready, rsp_valid, rsp_rdata, rsp_err, mem_memRead and mem_memWrite are 0; mem_address and mem_writeData are 0. Pointer set so port 0 wins the first tie.
- Reset mid-operation: an in-flight command is dropped and no response is issued. A write whose command cycle coincides with the reset-sampling edge still commits, because the memory itself is not reset.
- ready is forced to 0 while rst_n is low.
- Simultaneous accept and response for the same port in one cycle is legal.

## Structure
- Package data_mem_arb_pkg holds:
  - DEPTH, DATA_W and ADDR_W defaults
  - requester-id enum: REQ_CPU = 0, REQ_AUX = 1
  - command struct: id, we, addr, wdata, err
- Sub-module rr_arbiter2: two-way round-robin grant with last-grant pointer. Inputs are the valids and an accept strobe; outputs are one-hot grants.
- Top level: arbiter instance, command register, response register.

## Test plan
- Reset, then port 0 writes 0x1234 to addr 5; 4 cycles later port 0 reads addr 5 -> read rsp0_valid pulses 2 cycles after its accept with rdata 0x1234 and err 0. The write also gets an rsp0_valid pulse with rdata 0 and err 0.
- Both ports issue continuous reads (port 0 addr 3, port 1 addr 7), memory preloaded with 7 and 9 -> grants alternate 0,1,0,1 starting with port 0. Responses alternate rdata 7 and 9, one per cycle.
- Port 1 reads addr 64 and addr 65 -> addr 64 returns err 0; addr 65 returns err 1 with rdata 0, and both strobes stay 0 in its command cycle.
- Port 0 writes 0xA to addr 2, then immediately reads addr 2 in the next cycle -> read response 0xA.
- Assert rst_n low one cycle after accepting port 1's read -> no rsp1_valid is ever issued. All outputs are 0 the cycle after the reset edge, and port 0 wins the first tie after release.
- Random valid/we/addr stimulus on both ports against a scoreboard memory model -> no data mismatches. ready is never high on both ports at once, and neither port waits more than one accept for a grant under contention.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Command bundle carried from the grant point into the memory stage.
package data_mem_arb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 65;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_AUX = 1'b1
   } req_id_e;

   typedef struct packed {
      req_id_e           id;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              err;
   } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// On a tie the port not granted last wins.
module rr_arbiter2
   import data_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   req_id_e last;

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last == REQ_AUX) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset to "AUX granted last" so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= REQ_AUX;
      end else if (accept) begin
         last <= grant[1] ? REQ_AUX : REQ_CPU;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-ported data memory between CPU and aux master.
// Accept -> command (strobes) -> response, one access per cycle.
module data_mem_arbiter #(
   parameter int DATA_W = data_mem_arb_pkg::DATA_W,
   parameter int ADDR_W = data_mem_arb_pkg::ADDR_W,
   parameter int DEPTH  = data_mem_arb_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   input  logic [DATA_W-1:0] mem_readData
);

   import data_mem_arb_pkg::*;

   logic [1:0] gnt;
   logic [1:0] ready;
   logic       acc;
   logic       sel;
   logic       cmd_vld;
   logic       rd_hit;
   cmd_t       nxt;
   cmd_t       cmd;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  ({req1_valid, req0_valid}),
      .accept (acc),
      .grant  (gnt)
   );

   assign ready      = rst_n ? gnt : 2'b00;
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign acc        = |ready;
   assign sel        = ready[1];

   always_comb begin
      nxt       = '0;
      nxt.id    = sel ? REQ_AUX : REQ_CPU;
      nxt.we    = sel ? req1_we : req0_we;
      nxt.addr  = sel ? req1_addr : req0_addr;
      nxt.wdata = sel ? req1_wdata : req0_wdata;
      nxt.err   = (nxt.addr >= ADDR_W'(DEPTH));
   end

   // addr/wdata only move for in-range accesses, so the memory
   // bus holds its last value on idle and error cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_vld      <= 1'b0;
         cmd          <= '0;
         mem_memRead  <= 1'b0;
         mem_memWrite <= 1'b0;
      end else begin
         cmd_vld      <= acc;
         mem_memRead  <= acc && !nxt.err && !nxt.we;
         mem_memWrite <= acc && !nxt.err && nxt.we;
         if (acc) begin
            cmd.id  <= nxt.id;
            cmd.we  <= nxt.we;
            cmd.err <= nxt.err;
            if (!nxt.err) begin
               cmd.addr  <= nxt.addr;
               cmd.wdata <= nxt.wdata;
            end
         end
      end
   end

   assign mem_address   = cmd.addr;
   assign mem_writeData = cmd.wdata;
   assign rd_hit        = cmd_vld && !cmd.we && !cmd.err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
      end else begin
         rsp0_valid <= cmd_vld && (cmd.id == REQ_CPU);
         rsp0_err   <= cmd_vld && (cmd.id == REQ_CPU) && cmd.err;
         rsp0_rdata <= (rd_hit && cmd.id == REQ_CPU) ? mem_readData : '0;
         rsp1_valid <= cmd_vld && (cmd.id == REQ_AUX);
         rsp1_err   <= cmd_vld && (cmd.id == REQ_AUX) && cmd.err;
         rsp1_rdata <= (rd_hit && cmd.id == REQ_AUX) ? mem_readData : '0;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural memory.
// Expected responses are queued at accept and popped on rsp_valid.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v   [2];
   logic        wen [2];
   logic [31:0] adr [2];
   logic [31:0] wd  [2];
   logic        rdy [2];
   logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic [31:0] mem_address, mem_writeData, mem_readData;
   logic        mem_memRead, mem_memWrite;

   logic [31:0] mem     [0:64];
   logic [31:0] ref_mem [0:64];

   typedef struct {
      int          p;
      logic [31:0] d;
      logic        e;
      int          c;
   } exp_t;

   exp_t        sq[$];
   int          glog[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          wcnt    [2];
   logic        e_rd = 1'b0, e_wr = 1'b0;
   logic [31:0] e_addr, e_wd;
   logic [31:0] last_rdata;
   logic        last_err;

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req0_valid    (v[0]),
      .req0_we       (wen[0]),
      .req0_addr     (adr[0]),
      .req0_wdata    (wd[0]),
      .req0_ready    (rdy[0]),
      .req1_valid    (v[1]),
      .req1_we       (wen[1]),
      .req1_addr     (adr[1]),
      .req1_wdata    (wd[1]),
      .req1_ready    (rdy[1]),
      .rsp0_valid    (rsp0_valid),
      .rsp0_rdata    (rsp0_rdata),
      .rsp0_err      (rsp0_err),
      .rsp1_valid    (rsp1_valid),
      .rsp1_rdata    (rsp1_rdata),
      .rsp1_err      (rsp1_err),
      .mem_address   (mem_address),
      .mem_writeData (mem_writeData),
      .mem_memRead   (mem_memRead),
      .mem_memWrite  (mem_memWrite),
      .mem_readData  (mem_readData)
   );

   // Combinational-read, edge-write memory; junk when not read.
   assign mem_readData = (mem_memRead && mem_address < 65)
                         ? mem[mem_address[6:0]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (mem_memWrite && mem_address < 65)
         mem[mem_address[6:0]] <= mem_writeData;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      int   o;
      chk("strb_rd", 64'(mem_memRead), 64'(e_rd));
      chk("strb_wr", 64'(mem_memWrite), 64'(e_wr));
      if (e_rd || e_wr) chk("mem_addr", 64'(mem_address), 64'(e_addr));
      if (e_wr) chk("mem_wdata", 64'(mem_writeData), 64'(e_wd));
      chk("rsp_both", 64'(rsp0_valid & rsp1_valid), 64'd0);
      chk("rdy_both", 64'(rdy[0] & rdy[1]), 64'd0);
      for (int p = 0; p < 2; p++)
         chk("rdy_novld", 64'(rdy[p] & ~v[p]), 64'd0);
      if (rsp0_valid || rsp1_valid) begin
         chk("rsp_pending", 64'(sq.size() > 0), 64'd1);
         if (sq.size() > 0) begin
            x = sq.pop_front();
            last_rdata = rsp1_valid ? rsp1_rdata : rsp0_rdata;
            last_err   = rsp1_valid ? rsp1_err : rsp0_err;
            chk("rsp_port", 64'(rsp1_valid), 64'(x.p));
            chk("rsp_rdata", 64'(last_rdata), 64'(x.d));
            chk("rsp_err", 64'(last_err), 64'(x.e));
            chk("rsp_lat", 64'(cyc - x.c), 64'd2);
         end
      end
      e_rd = 1'b0;
      e_wr = 1'b0;
      if (!rst_n) begin
         chk("rdy_rst", 64'(rdy[0] | rdy[1]), 64'd0);
         sq.delete();
         wcnt[0] = 0;
         wcnt[1] = 0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (v[p] && rdy[p]) begin
               logic inr;
               o   = 1 - p;
               inr = adr[p] < 65;
               x.p = p;
               x.e = !inr;
               x.c = cyc;
               x.d = (!wen[p] && inr) ? ref_mem[adr[p][6:0]] : 32'd0;
               if (wen[p] && inr) ref_mem[adr[p][6:0]] = wd[p];
               sq.push_back(x);
               glog.push_back(p);
               e_rd   = inr && !wen[p];
               e_wr   = inr && wen[p];
               e_addr = adr[p];
               e_wd   = wd[p];
               if (v[o]) begin
                  wcnt[o]++;
                  chk("fair", 64'(wcnt[o] > 1), 64'd0);
               end
               wcnt[p] = 0;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input int p, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      v[p]   = 1'b1;
      wen[p] = w;
      adr[p] = a;
      wd[p]  = d;
      @(negedge clk);
      while (!rdy[p] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("grant_timeout", 64'(rdy[p]), 64'd1);
      if (rdy[p]) begin
         @(posedge clk);
         #1;
      end
      v[p] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sq.size() != 0 && n < 20) begin
         step(1);
         n++;
      end
      chk("drain", 64'(sq.size()), 64'd0);
      step(2);
   endtask

   initial begin
      for (int i = 0; i < 65; i++) begin
         mem[i]     = 32'd0;
         ref_mem[i] = 32'd0;
      end
      for (int p = 0; p < 2; p++) begin
         v[p] = 1'b0; wen[p] = 1'b0; adr[p] = '0; wd[p] = '0;
         wcnt[p] = 0;
      end
      mem[3] = 32'd7;  ref_mem[3] = 32'd7;
      mem[7] = 32'd9;  ref_mem[7] = 32'd9;
      step(3);
      chk("rst_rsp", 64'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 64'd0);
      chk("rst_rdata", 64'(rsp0_rdata | rsp1_rdata), 64'd0);
      chk("rst_addr", 64'(mem_address), 64'd0);
      chk("rst_wdata", 64'(mem_writeData), 64'd0);
      rst_n = 1'b1;
      step(1);

      // Contention: continuous reads on both ports.
      fork
         for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'd3, 32'd0);
         for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'd7, 32'd0);
      join
      drain();
      chk("glog_n", 64'(glog.size()), 64'd8);
      for (int i = 0; i < 8 && i < glog.size(); i++)
         chk("alternate", 64'(glog[i]), 64'(i % 2));

      issue(0, 1'b1, 32'd5, 32'h1234);
      step(4);
      issue(0, 1'b0, 32'd5, 32'd0);
      drain();
      chk("rd_addr5", 64'(last_rdata), 64'h1234);

      issue(1, 1'b0, 32'd64, 32'd0);
      drain();
      chk("addr64_err", 64'(last_err), 64'd0);
      issue(1, 1'b0, 32'd65, 32'd0);
      drain();
      chk("addr65_err", 64'(last_err), 64'd1);
      chk("addr65_rdata", 64'(last_rdata), 64'd0);

      issue(0, 1'b1, 32'd2, 32'hA);
      issue(0, 1'b0, 32'd2, 32'd0);
      drain();
      chk("raw_addr2", 64'(last_rdata), 64'hA);

      // Reset during the command cycle of a port-1 read.
      issue(1, 1'b0, 32'd7, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rr_rsp", 64'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 64'd0);
      chk("rr_rdata", 64'(rsp0_rdata | rsp1_rdata), 64'd0);
      chk("rr_strb", 64'({mem_memRead, mem_memWrite}), 64'd0);
      chk("rr_addr", 64'(mem_address), 64'd0);
      chk("rr_wdata", 64'(mem_writeData), 64'd0);
      chk("rr_ready", 64'({rdy[0], rdy[1]}), 64'd0);
      step(1);
      rst_n = 1'b1;
      step(3);
      glog.delete();
      fork
         issue(0, 1'b0, 32'd3, 32'd0);
         issue(1, 1'b0, 32'd3, 32'd0);
      join
      drain();
      chk("tie_after_rst", 64'(glog.size() > 0 ? glog[0] : 9), 64'd0);

      fork
         for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 2));
            issue(0, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70)
                                              : $urandom_range(0, 7),
                  $urandom);
         end
         for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 2));
            issue(1, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70)
                                              : $urandom_range(0, 7),
                  $urandom);
         end
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
